detector_arbiter: RTL and testbench
===================================

Name: detector_arbiter

Overview:
- Round-robin scheduler that shares one serial pattern-detector core among N requesters.
- The granted requester's FRAME_LEN-bit word is serialized MSB first into the core, one bit per clk.
- The number of pattern matches in that frame is returned with a done pulse.
- Sits between parallel producers and the single serial sequence-detector FSM; it clears and sequences the detector between frames.

Parameters:
- N, 4, number of requesters (2..8)
- FRAME_LEN, 16, bits per frame
- PAT_LEN, 4, pattern length in bits (2..8, ≤ FRAME_LEN)
- PATTERN, 4'b1011, pattern to detect; the first bit in time is the MSB

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req  in  N  per-requester request, level
- data  in  N*FRAME_LEN  frame words; requester i occupies bits [i*FRAME_LEN +: FRAME_LEN]
- grant  out  N  one-hot grant, high from CLEAR through REPORT
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in REPORT
- done_id  out  $clog2(N)  index of the requester served; valid while done=1
- match_cnt  out  $clog2(FRAME_LEN+1)  matches in the frame; valid while done=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grant=0, busy=0, done=0, done_id=0, match_cnt=0; RR pointer=0; shift register and detector history cleared. Reset asserted mid-frame abandons the frame silently, with no done pulse.
- FSM states:
  - IDLE: if any req bit is high, select the first requester at or after the pointer (cyclic order). Capture its data word into the shift register and its index. Go to CLEAR. Otherwise stay in IDLE.
  - CLEAR (1 cycle): grant asserted; detector history, valid-bit counter and match counter zeroed. Go to SHIFT.
  - SHIFT (FRAME_LEN cycles): each cycle feed the shift-register MSB to the detector and shift left; bit counter increments. After the last bit, go to REPORT.
  - REPORT (1 cycle): done=1, done_id and match_cnt driven. Pointer becomes served index + 1 (mod N). Go to IDLE.
- Latency: req sampled in IDLE at cycle 0 → grant rises at cycle 1 → done at cycle FRAME_LEN+2. The next grant can rise no earlier than cycle FRAME_LEN+4.
- Handshake: req must stay high until done.
  - Data is sampled only at IDLE→CLEAR; later changes to data are ignored.
  - req dropping mid-frame is ignored and the frame completes.
  - A requester still asserting req after its done is treated as a new request.
- Detector rules:
  - A match is counted in the SHIFT cycle whose bit completes PATTERN over the last PAT_LEN bits.
  - A match requires at least PAT_LEN valid bits since CLEAR, so cleared history never false-matches.
  - Overlapping matches are counted.
  - match_cnt saturates at 2^width−1; this is unreachable with legal parameters.
- Simultaneous requests: exactly one winner per arbitration, by round-robin order. No requester is starved: each waits at most N−1 frames.

Optional Feature:
- Macro: DETECTOR_ARBITER_NONOVERLAP_EN.
- Defined: after a match, the valid-bit counter is reset to 0, so matches cannot share bits (non-overlapping count).
- Undefined: overlapping count as described above.
- Timing and the interface are identical in both builds.

Decomposition:
- Shared package: arb_state_t enum (IDLE, CLEAR, SHIFT, REPORT); width constants CNT_W=$clog2(FRAME_LEN+1) and ID_W=$clog2(N); a function returning the next round-robin index.
- Sub-module pattern_detector:
  - Inputs: clk, reset, clear, bit_valid, bit_in.
  - Outputs: match (combinational) and match_cnt (registered).
  - Parameters: PAT_LEN, PATTERN, FRAME_LEN.
  - The top level holds the FSM, arbiter and serializer.

Test Plan:
- Reset, then req=4'b0001 with data0=16'hB6DB → grant=0001 at cycle 1, done at cycle 18, done_id=0, match_cnt=5 (3 with DETECTOR_ARBITER_NONOVERLAP_EN).
- data0=16'h0000, then a separate frame with 16'hFFFF → both frames give match_cnt=0, checking no false match from cleared history.
- data0=16'h000B → match_cnt=1, checking that a match on the final bit is counted.
- req=4'b1011 held high from reset → grants served in order 0,1,3,0,…; done_id sequence 0,1,3,0; exactly one grant bit high at any time; 19-cycle frame spacing.
- Drop req0 and change data0 mid-SHIFT → the frame completes with the originally captured word; match_cnt unchanged.
- Assert reset=0 during SHIFT → all outputs 0 immediately with no done pulse; after release, a pending req2 is served first (pointer=0, next requester at or after it).

Source files
------------

// File: rtl/detector_arbiter_pkg.sv
// Shared types and helpers for the round-robin pattern-detector scheduler.
package detector_arbiter_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned FRAME_LEN_DEF = 16;
  localparam int unsigned CNT_W = $clog2(FRAME_LEN_DEF + 1);
  localparam int unsigned ID_W = $clog2(N_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StShift,
    StReport
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/detector_arbiter_pattern_detector.sv
// Serial pattern detector with match counter; counts overlapping matches unless
// DETECTOR_ARBITER_NONOVERLAP_EN is defined, which restarts the window after each match.
module detector_arbiter_pattern_detector
  import detector_arbiter_pkg::*;
#(
  parameter int unsigned           PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0]    PATTERN   = 4'b1011,
  parameter int unsigned           FRAME_LEN = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             bit_valid_i,
  input  logic                             bit_in_i,
  output logic                             match_o,
  output logic [$clog2(FRAME_LEN+1)-1:0]   match_cnt_o
);

  localparam int unsigned VldW = $clog2(PAT_LEN + 1);
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [VldW-1:0]    vld_q, vld_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PAT_LEN-1:0] window;

  always_comb begin
    window  = {hist_q, bit_in_i};
    // Needs PAT_LEN-1 prior valid bits plus this one, so cleared history never matches.
    match_o = bit_valid_i && (vld_q >= VldW'(PAT_LEN - 1)) && (window == PATTERN);
  end

  always_comb begin
    hist_d = hist_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      hist_d = '0;
      vld_d  = '0;
      cnt_d  = '0;
    end else if (bit_valid_i) begin
      hist_d = window[PAT_LEN-2:0];
      if (vld_q != VldW'(PAT_LEN)) vld_d = vld_q + 1'b1;
      if (match_o && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
`ifdef DETECTOR_ARBITER_NONOVERLAP_EN
      if (match_o) vld_d = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt_o = cnt_q;

endmodule

// File: rtl/detector_arbiter.sv
// Round-robin scheduler serializing one requester's frame at a time into a shared detector.
// Build option DETECTOR_ARBITER_NONOVERLAP_EN selects non-overlapping match counting.
module detector_arbiter
  import detector_arbiter_pkg::*;
#(
  parameter int unsigned        N         = 4,
  parameter int unsigned        FRAME_LEN = 16,
  parameter int unsigned        PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1011
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N-1:0]                     req_i,
  input  logic [N*FRAME_LEN-1:0]           data_i,
  output logic [N-1:0]                     grant_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [$clog2(N)-1:0]             done_id_o,
  output logic [$clog2(FRAME_LEN+1)-1:0]   match_cnt_o
);

  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
  localparam int unsigned BitW = $clog2(FRAME_LEN);

  arb_state_t           state_q, state_d;
  logic [FRAME_LEN-1:0] sreg_q, sreg_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [BitW-1:0]      bitcnt_q, bitcnt_d;

  logic                 found;
  logic [IdW-1:0]       win;
  logic [FRAME_LEN-1:0] win_word;
  int unsigned          cand;
  logic                 det_clear, det_valid, done;
  logic                 match_unused;
  logic [CntW-1:0]      det_cnt;

  // First requester at or after the pointer, in cyclic order.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!found && req_i[IdW'(cand)]) begin
        found = 1'b1;
        win   = IdW'(cand);
      end
    end
    win_word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (IdW'(k) == win) win_word = data_i[k*FRAME_LEN +: FRAME_LEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    bitcnt_d  = bitcnt_q;
    det_clear = 1'b0;
    det_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          sreg_d  = win_word;
          id_d    = win;
          state_d = StClear;
        end
      end
      StClear: begin
        det_clear = 1'b1;
        bitcnt_d  = '0;
        state_d   = StShift;
      end
      StShift: begin
        det_valid = 1'b1;
        sreg_d    = sreg_q << 1;
        bitcnt_d  = bitcnt_q + 1'b1;
        if (bitcnt_q == BitW'(FRAME_LEN - 1)) state_d = StReport;
      end
      StReport: begin
        done    = 1'b1;
        ptr_d   = IdW'(rr_next(int'(id_q), N));
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sreg_q   <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  detector_arbiter_pattern_detector #(
    .PAT_LEN   (PAT_LEN),
    .PATTERN   (PATTERN),
    .FRAME_LEN (FRAME_LEN)
  ) u_detector (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (det_clear),
    .bit_valid_i (det_valid),
    .bit_in_i    (sreg_q[FRAME_LEN-1]),
    .match_o     (match_unused),
    .match_cnt_o (det_cnt)
  );

  always_comb begin
    busy_o      = (state_q != StIdle);
    grant_o     = busy_o ? (N'(1) << id_q) : '0;
    done_o      = done;
    done_id_o   = done ? id_q : '0;
    match_cnt_o = done ? det_cnt : '0;
  end

endmodule

// File: tb/tb_detector_arbiter.sv
// Directed self-checking bench for detector_arbiter (N=4, FRAME_LEN=16, PATTERN=1011).
module tb_detector_arbiter;

  localparam int N  = 4;
  localparam int FL = 16;
`ifdef DETECTOR_ARBITER_NONOVERLAP_EN
  localparam int ExpB6db = 3;
`else
  localparam int ExpB6db = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*FL-1:0] data;
  logic [N-1:0]  grant;
  logic          busy;
  logic          done;
  logic [1:0]    done_id;
  logic [4:0]    match_cnt;

  int checks = 0;
  int errors = 0;
  int onehot_bad = 0;

  always #5 clk = ~clk;

  detector_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .data_i      (data),
    .grant_o     (grant),
    .busy_o      (busy),
    .done_o      (done),
    .done_id_o   (done_id),
    .match_cnt_o (match_cnt)
  );

  // Grant must be one-hot exactly while busy.
  always @(negedge clk) begin
    if (rst_n && (busy ? !$onehot(grant) : (grant != '0))) onehot_bad++;
  end

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id got %0d exp 0", done_id); end
    checks++; if (match_cnt !== 5'd0) begin errors++; $display("FAIL reset_match_cnt got %0d exp 0", match_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    data[0*FL +: FL] = 16'hB6DB;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL basic_grant_c1 got %b exp 0001", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1 got %b exp 1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL basic_done_cycle got %0d exp 17 (cycle 18)", cyc); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL basic_done_id got %0d exp 0", done_id); end
    checks++; if (match_cnt !== 5'(ExpB6db)) begin errors++; $display("FAIL basic_match_cnt got %0d exp %0d", match_cnt, ExpB6db); end
    req = '0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", busy); end
  endtask

  task automatic test_no_false_match();
    int cyc;
    data[0*FL +: FL] = 16'h0000;
    req = 4'b0001;
    wait_done(cyc);
    checks++; if (cyc !== 18) begin errors++; $display("FAIL zeros_done_cycle got %0d exp 18", cyc); end
    checks++; if (match_cnt !== 5'd0) begin errors++; $display("FAIL zeros_match_cnt got %0d exp 0", match_cnt); end
    req = '0;
    @(negedge clk);
    data[0*FL +: FL] = 16'hFFFF;
    req = 4'b0001;
    wait_done(cyc);
    checks++; if (cyc !== 18) begin errors++; $display("FAIL ones_done_cycle got %0d exp 18", cyc); end
    checks++; if (match_cnt !== 5'd0) begin errors++; $display("FAIL ones_match_cnt got %0d exp 0", match_cnt); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_last_bit();
    int cyc;
    data[0*FL +: FL] = 16'h000B;
    req = 4'b0001;
    wait_done(cyc);
    checks++; if (cyc !== 18) begin errors++; $display("FAIL lastbit_done_cycle got %0d exp 18", cyc); end
    checks++; if (match_cnt !== 5'd1) begin errors++; $display("FAIL lastbit_match_cnt got %0d exp 1", match_cnt); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cyc;
    int exp_id  [4] = '{0, 1, 3, 0};
    int exp_cyc [4] = '{18, 19, 19, 19};
    int exp_cnt [4];
    exp_cnt = '{ExpB6db, 1, 0, ExpB6db};
    rst_n = 1'b0;
    data[0*FL +: FL] = 16'hB6DB;
    data[1*FL +: FL] = 16'h000B;
    data[2*FL +: FL] = 16'hFFFF;
    data[3*FL +: FL] = 16'h0000;
    req = 4'b1011;
    @(negedge clk);
    onehot_bad = 0;
    rst_n = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_done(cyc);
      checks++; if (cyc !== exp_cyc[f]) begin errors++; $display("FAIL rr_spacing[%0d] got %0d exp %0d", f, cyc, exp_cyc[f]); end
      checks++; if (done_id !== 2'(exp_id[f])) begin errors++; $display("FAIL rr_done_id[%0d] got %0d exp %0d", f, done_id, exp_id[f]); end
      checks++; if (match_cnt !== 5'(exp_cnt[f])) begin errors++; $display("FAIL rr_match_cnt[%0d] got %0d exp %0d", f, match_cnt, exp_cnt[f]); end
    end
    req = '0;
    @(negedge clk);
    checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL rr_onehot_grant got %0d bad cycles exp 0", onehot_bad); end
  endtask

  task automatic test_mid_frame_change();
    int cyc;
    data[0*FL +: FL] = 16'hB6DB;
    req = 4'b0001;
    repeat (6) @(negedge clk);
    req = '0;
    data[0*FL +: FL] = 16'hFFFF;
    wait_done(cyc);
    checks++; if (cyc !== 12) begin errors++; $display("FAIL midchg_done_cycle got %0d exp 12", cyc); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL midchg_done_id got %0d exp 0", done_id); end
    checks++; if (match_cnt !== 5'(ExpB6db)) begin errors++; $display("FAIL midchg_match_cnt got %0d exp %0d", match_cnt, ExpB6db); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    int done_seen;
    // Serve requester 2 so the pointer sits at 3 before the reset.
    data[2*FL +: FL] = 16'h000B;
    req = 4'b0100;
    wait_done(cyc);
    checks++; if (done_id !== 2'd2) begin errors++; $display("FAIL rstmid_setup_id got %0d exp 2", done_id); end
    req = '0;
    @(negedge clk);
    data[3*FL +: FL] = 16'hB6DB;
    req = 4'b1000;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1100;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if ({done, done_id, match_cnt} !== 8'd0) begin errors++; $display("FAIL rstmid_outputs got %h exp 00", {done, done_id, match_cnt}); end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses exp 0", done_seen); end
    rst_n = 1'b1;
    wait_done(cyc);
    checks++; if (cyc !== 18) begin errors++; $display("FAIL rstmid_done_cycle got %0d exp 18", cyc); end
    checks++; if (done_id !== 2'd2) begin errors++; $display("FAIL rstmid_done_id got %0d exp 2", done_id); end
    checks++; if (match_cnt !== 5'd1) begin errors++; $display("FAIL rstmid_match_cnt got %0d exp 1", match_cnt); end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_false_match();
    test_last_bit();
    test_round_robin();
    test_mid_frame_change();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
